// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the register-file read stage and the multiply/divide unit.
// The master drives operands and control; the slave returns busy/done and HI/LO.
interface muldiv_unit_if #(parameter int XLEN = 32);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs_data;
   logic [XLEN-1:0] rt_data;
   logic            flush;
   logic            hi_we;
   logic            lo_we;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on magnitudes and applies the sign fixup in the final state.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_m;
   logic [XLEN-1:0]   r_rs;
   logic              r_is_div;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_div0;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_busy;
   logic              r_done;

   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_abs;
   logic [XLEN-1:0]   w_b_abs;
   logic [XLEN:0]     w_add;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_mul_next;
   logic [2*XLEN-1:0] w_div_next;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;

   assign w_a_neg = ~bus.op[0] & bus.rs_data[XLEN-1];
   assign w_b_neg = ~bus.op[0] & bus.rt_data[XLEN-1];
   assign w_a_abs = w_a_neg ? -bus.rs_data : bus.rs_data;
   assign w_b_abs = w_b_neg ? -bus.rt_data : bus.rt_data;

   // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, then shift right.
   assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
   assign w_mul_next = {w_add, r_acc[XLEN-1:1]};

   // Divide: acc = {remainder, dividend}; shift left and keep the subtraction when it does not borrow.
   assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_m};
   assign w_div_next = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                     : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_m      <= '0;
         r_rs     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  r_state  <= CALC;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_rs     <= bus.rs_data;
                  r_is_div <= bus.op[1];
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_div0   <= bus.op[1] && (bus.rt_data == '0);
                  r_m      <= bus.op[1] ? w_b_abs : w_a_abs;
                  r_acc    <= {{XLEN{1'b0}}, (bus.op[1] ? w_a_abs : w_b_abs)};
               end else if (!bus.start) begin
                  if (bus.hi_we) r_hi <= bus.wdata;
                  if (bus.lo_we) r_lo <= bus.wdata;
               end
            end
            CALC: begin
               if (bus.flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(XLEN-1)) r_state <= FIN;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               if (!bus.flush) begin
                  r_done <= 1'b1;
                  if (r_div0) begin
                     r_hi <= r_rs;
                     r_lo <= '1;
                  end else if (r_is_div) begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end else begin
                     r_hi <= w_prod[2*XLEN-1:XLEN];
                     r_lo <= w_prod[XLEN-1:0];
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit that sits directly downstream of the register file read ports.
- Consumes ReadData1/ReadData2 as rs/rt operands and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds results in architectural HI/LO registers and supports MTHI/MTLO writes.
- Pipeline control uses busy to stall issue while an operation is in flight.

Parameters:
- XLEN, 32: operand width; also the number of iteration cycles.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  XLEN  operand A (multiplicand / dividend), from ReadData1.
- rt_data  input  XLEN  operand B (multiplier / divisor), from ReadData2.
- flush  input  1  abort the in-flight operation.
- hi_we  input  1  MTHI: write wdata into HI.
- lo_we  input  1  MTLO: write wdata into LO.
- wdata  input  XLEN  data for hi_we/lo_we.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; HI/LO hold the new result while high.
- hi  output  XLEN  HI register (high product / remainder).
- lo  output  XLEN  LO register (low product / quotient).

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal operand regs=0.
- FSM states: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0:
  - Latch op, rs_data, rt_data.
  - Signed ops: latch absolute values plus the result-sign flags (product sign = a^b; quotient sign = a^b; remainder sign = a).
  - Go to CALC, counter=0.
  - busy goes high in the cycle after E0.
- CALC: one radix-2 step per edge.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract.
  - Counter increments each edge. The edge at which counter==XLEN-1 moves to FIN (edges E1..E32).
- FIN (edge E33):
  - Apply sign fixup (two's-complement negate where the flag is set).
  - Write hi/lo and set done=1 for exactly one cycle.
  - Return to IDLE. busy is low in the same cycle that done is high.
- Latency: start sampled at E0 -> done high in the cycle after E33 (34 edges). A new start is accepted in the done cycle.
- Multiply results: {hi,lo} = full 2*XLEN product. Signed/unsigned is selected by op[0] (0 = signed).
- Divide results: lo = quotient, hi = remainder; quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU, rt_data=0): lo=all ones, hi=rs_data unchanged. Same 34-edge latency, done pulses.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. No trap.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Effective only in IDLE with start=0; write at the edge.
  - hi_we and lo_we together write both registers.
  - Ignored when busy or when start=1.
- flush:
  - In CALC or FIN: return to IDLE at the next edge; hi/lo unchanged; no done pulse.
  - In IDLE: no effect, and it blocks start in that cycle.
- Reset asserted mid-operation: immediate abort to the reset values; no done pulse after reset releases.
- op and operand inputs may change freely after E0; the latched copies are used.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy for 34 edges, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x00000064 rt=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Start MULTU 5*6; at edge E10 pulse start with a different op and hi_we=1 wdata=0xAAAAAAAA -> both ignored; final hi=0, lo=0x1E.
- In IDLE, hi_we=1 wdata=0x12345678 and lo_we=1 -> hi=lo=0x12345678 after 1 edge. Start DIVU 9/2, flush at E5 -> busy drops next edge, no done, hi/lo still 0x12345678.
- Start MULT 3*3, drive rst=0 at E20 (between edges) -> hi=lo=0, busy=0 immediately. Release reset, wait 40 cycles -> done never pulses.
